// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared definitions for the multiplexed seven-segment scanner.
//   SEG_OFF      : all segments dark (active-low outputs)
//   GLYPH        : nibble-to-segment table, bit6=A ... bit0=G, active-low
//   slot_cycles  : sysclk cycles per digit slot
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex glyphs 0..F, segment bit6=A ... bit0=G, a 0 lights the segment.
    localparam logic [6:0] GLYPH [16] = '{
        7'h01, // 0
        7'h4F, // 1
        7'h12, // 2
        7'h06, // 3
        7'h4C, // 4
        7'h24, // 5
        7'h20, // 6
        7'h0F, // 7
        7'h00, // 8
        7'h04, // 9
        7'h08, // A
        7'h60, // b
        7'h31, // C
        7'h42, // d
        7'h30, // E
        7'h38  // F
    };

    function automatic int slot_cycles(input int clk_hz, input int slot_hz);
        return clk_hz / slot_hz;
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph -- combinational hex nibble to seven-segment decode.
//   nibble : input  4  hex value
//   seg    : output 7  active-low segments, bit6=A ... bit0=G
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = GLYPH[nibble];

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan -- time-multiplexed seven-segment display driver.
//   sysclk      : input  1         system clock, rising edge
//   rst_n       : input  1         asynchronous active-low reset
//   show        : input  4*DIGITS  hex nibbles, digit 0 rightmost
//   dp_in       : input  DIGITS    decimal point request per digit
//   blank_in    : input  DIGITS    force digit dark
//   lzs_en      : input  1         leading-zero suppression enable
//   bright      : input  3         brightness, 0 = 1/8 duty, 7 = full
//   seg         : output 7         active-low segments, bit6=A ... bit0=G
//   dp          : output 1         active-low decimal point
//   an          : output DIGITS    active-low anodes, at most one low
//   frame_start : output 1         pulse in the cycle after a snapshot
// Inputs are captured once per frame so a digit sequence never mixes two
// values. Each slot opens with BLANK_CYC dark cycles during which seg/dp
// switch to the next digit, so a lit digit never shows a segment change.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int CLK_HZ    = 100_000_000,
    parameter int SLOT_HZ   = 1000,
    parameter int BLANK_CYC = 64
) (
    input  logic                  sysclk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   show,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  lzs_en,
    input  logic [2:0]            bright,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);

    localparam int SLOT_CYC = slot_cycles(CLK_HZ, SLOT_HZ);
    localparam int SLOT_W   = $clog2(SLOT_CYC);
    localparam int DIG_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("seg7_scan: DIGITS must be 1..8");
    end
    if (SLOT_CYC < BLANK_CYC + 2) begin : g_bad_slot
        $error("seg7_scan: SLOT_CYC must be at least BLANK_CYC+2");
    end

    logic [SLOT_W-1:0]     slot_cnt;
    logic [DIG_W-1:0]      dig_idx;
    logic [2:0]            pwm_cnt;
    logic                  first_clk;

    logic [4*DIGITS-1:0]   show_s;
    logic [DIGITS-1:0]     dp_s;
    logic [DIGITS-1:0]     blank_s;
    logic                  lzs_s;
    logic [2:0]            bright_s;

    logic                  slot_last;
    logic                  dig_last;
    logic                  snap_take;
    logic [SLOT_W-1:0]     slot_nxt;
    logic [DIG_W-1:0]      dig_nxt;

    logic [DIGITS-1:0]     dark_vec;
    logic                  lead;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_dark;
    logic [6:0]            cur_seg;
    logic                  lit_win;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic [DIGITS-1:0]     an_nxt;

    assign slot_last = (slot_cnt == SLOT_W'(SLOT_CYC - 1));
    assign dig_last  = (dig_idx == DIG_W'(DIGITS - 1));
    // Snapshot on the first clock out of reset and whenever digit index wraps.
    assign snap_take = first_clk | (slot_last & dig_last);
    assign slot_nxt  = slot_last ? '0 : slot_cnt + SLOT_W'(1);
    assign dig_nxt   = !slot_last ? dig_idx : (dig_last ? '0 : dig_idx + DIG_W'(1));

    // Leading-zero chain runs from the leftmost digit down to digit 1; a
    // non-zero nibble or a set decimal point ends the run of suppression.
    always_comb begin
        dark_vec = blank_s;
        lead     = lzs_s;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead = lead & (show_s[4*i +: 4] == 4'd0) & ~dp_s[i];
            if (lead) begin
                dark_vec[i] = 1'b1;
            end
        end
    end

    assign lit_win = (slot_cnt >= SLOT_W'(BLANK_CYC)) && (pwm_cnt <= bright_s);

    always_comb begin
        cur_nib  = 4'd0;
        cur_dp   = 1'b0;
        cur_dark = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_idx == DIG_W'(i)) begin
                cur_nib  = show_s[4*i +: 4];
                cur_dp   = dp_s[i];
                cur_dark = dark_vec[i];
            end
        end
    end

    seg7_glyph u_glyph (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    always_comb begin
        seg_nxt = cur_dark ? SEG_OFF : cur_seg;
        dp_nxt  = cur_dark ? 1'b1 : ~cur_dp;
        an_nxt  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_idx == DIG_W'(i) && !cur_dark && lit_win) begin
                an_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt    <= '0;
            dig_idx     <= '0;
            pwm_cnt     <= 3'd0;
            first_clk   <= 1'b1;
            show_s      <= '0;
            dp_s        <= '0;
            blank_s     <= '0;
            lzs_s       <= 1'b0;
            bright_s    <= 3'd0;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            an          <= '1;
            frame_start <= 1'b0;
        end else begin
            first_clk   <= 1'b0;
            slot_cnt    <= slot_nxt;
            dig_idx     <= dig_nxt;
            pwm_cnt     <= pwm_cnt + 3'd1;
            if (snap_take) begin
                show_s   <= show;
                dp_s     <= dp_in;
                blank_s  <= blank_in;
                lzs_s    <= lzs_en;
                bright_s <= bright;
            end
            frame_start <= snap_take;
            seg         <= seg_nxt;
            dp          <= dp_nxt;
            an          <= an_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan -- directed bench for seg7_scan with DIGITS=4, SLOT_CYC=10,
// BLANK_CYC=2. A frame is 40 cycles; output sample k after release shows
// digit (k/10)%4, slot k%10.
module tb_seg7_scan;

    logic        sysclk;
    logic        rst_n;
    logic [15:0] show;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lzs_en;
    logic [2:0]  bright;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int vectors;
    int miscompares;

    // per-frame observations
    int         pos;
    int         fs_cnt;
    int         blank_viol;
    int         two_low;
    int         bad_an;
    int         seg_chg;
    int         lit_cnt [4];
    logic [6:0] lit_seg [4];
    logic       lit_dp  [4];
    logic [6:0] prev_seg;
    logic       prev_dp;

    seg7_scan #(
        .DIGITS    (4),
        .CLK_HZ    (1000),
        .SLOT_HZ   (100),
        .BLANK_CYC (2)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .show        (show),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .lzs_en      (lzs_en),
        .bright      (bright),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic clear_acc();
        fs_cnt     = 0;
        blank_viol = 0;
        two_low    = 0;
        bad_an     = 0;
        seg_chg    = 0;
        for (int i = 0; i < 4; i++) begin
            lit_cnt[i] = 0;
            lit_seg[i] = 7'h7F;
            lit_dp[i]  = 1'b1;
        end
    endtask

    task automatic observe(input int n);
        int         d;
        int         s;
        logic [3:0] exp_an;
        for (int t = 0; t < n; t++) begin
            tick();
            d = pos / 10;
            s = pos % 10;
            exp_an = ~(4'b0001 << d);
            if (frame_start === 1'b1) fs_cnt++;
            if (an !== 4'hF) begin
                if (s < 2) blank_viol++;
                if ($countones(~an) > 1) two_low++;
                if (an !== exp_an) begin
                    bad_an++;
                end else begin
                    lit_cnt[d]++;
                    lit_seg[d] = seg;
                    lit_dp[d]  = dp;
                end
                if (seg !== prev_seg || dp !== prev_dp) seg_chg++;
            end
            prev_seg = seg;
            prev_dp  = dp;
            pos = (pos == 39) ? 0 : pos + 1;
        end
    endtask

    task automatic check_frame(input string tag, input int exp_fs,
                               input logic [3:0][3:0] exp_lit,
                               input logic [3:0][6:0] exp_seg,
                               input logic [3:0]      exp_dp);
        chk($sformatf("%s frame_start pulses", tag), fs_cnt, exp_fs);
        chk($sformatf("%s lit in blanking", tag), blank_viol, 0);
        chk($sformatf("%s two anodes low", tag), two_low, 0);
        chk($sformatf("%s wrong anode", tag), bad_an, 0);
        chk($sformatf("%s seg change while lit", tag), seg_chg, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s lit cycles d%0d", tag, i), lit_cnt[i], 32'(exp_lit[i]));
            if (exp_lit[i] != 4'd0) begin
                chk($sformatf("%s seg d%0d", tag, i), 32'(lit_seg[i]), 32'(exp_seg[i]));
                chk($sformatf("%s dp d%0d", tag, i), 32'(lit_dp[i]), 32'(exp_dp[i]));
            end
        end
    endtask

    task automatic release_reset();
        @(negedge sysclk);
        rst_n    = 1'b1;
        pos      = 0;
        prev_seg = 7'h7F;
        prev_dp  = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        show        = 16'h12AF;
        dp_in       = 4'b0000;
        blank_in    = 4'b0000;
        lzs_en      = 1'b0;
        bright      = 3'd7;
        clear_acc();

        // reset state
        repeat (3) @(negedge sysclk);
        chk("reset an", 32'(an), 32'hF);
        chk("reset seg", 32'(seg), 32'h7F);
        chk("reset dp", 32'(dp), 32'h1);
        chk("reset frame_start", 32'(frame_start), 32'h0);

        // frame A: 12AF at full brightness; inputs change mid-frame
        release_reset();
        clear_acc();
        observe(20);
        show   = 16'h0045;
        lzs_en = 1'b1;
        observe(20);
        check_frame("A", 2, {4'd8, 4'd8, 4'd8, 4'd8},
                    {7'h4F, 7'h12, 7'h08, 7'h38}, 4'b1111);

        // frame B: 0045 with suppression
        clear_acc();
        observe(20);
        show = 16'h0000;
        observe(20);
        check_frame("B", 1, {4'd0, 4'd0, 4'd8, 4'd8},
                    {7'h7F, 7'h7F, 7'h4C, 7'h24}, 4'b1111);

        // frame C: all zero, only digit 0 survives
        clear_acc();
        observe(20);
        show  = 16'h0005;
        dp_in = 4'b0100;
        observe(20);
        check_frame("C", 1, {4'd0, 4'd0, 4'd0, 4'd8},
                    {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'b1111);

        // frame D: a decimal point stops suppression at digit 2
        clear_acc();
        observe(20);
        show   = 16'h1234;
        dp_in  = 4'b0000;
        lzs_en = 1'b0;
        bright = 3'd0;
        observe(20);
        check_frame("D", 1, {4'd0, 4'd8, 4'd8, 4'd8},
                    {7'h7F, 7'h01, 7'h01, 7'h24}, 4'b1011);

        // frame E: brightness 0 -> one lit cycle per 8-cycle window
        clear_acc();
        observe(20);
        bright = 3'd3;
        observe(20);
        check_frame("E", 1, {4'd1, 4'd1, 4'd1, 4'd1},
                    {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'b1111);

        // frame F: brightness 3 -> four lit cycles per window
        clear_acc();
        observe(20);
        bright   = 3'd7;
        blank_in = 4'b0010;
        observe(20);
        check_frame("F", 1, {4'd4, 4'd4, 4'd4, 4'd4},
                    {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'b1111);

        // frame G: digit 1 forced dark
        clear_acc();
        observe(40);
        check_frame("G", 1, {4'd8, 4'd8, 4'd0, 4'd8},
                    {7'h4F, 7'h12, 7'h7F, 7'h4C}, 4'b1111);

        // asynchronous reset in the middle of a lit slot
        repeat (5) tick();
        chk("pre-reset an", 32'(an), 32'hE);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset an", 32'(an), 32'hF);
        chk("async reset seg", 32'(seg), 32'h7F);
        chk("async reset dp", 32'(dp), 32'h1);
        chk("async reset frame_start", 32'(frame_start), 32'h0);
        show     = 16'h12AF;
        blank_in = 4'b0000;
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        chk("held reset an", 32'(an), 32'hF);

        // frame H: restart from digit 0, slot 0
        release_reset();
        clear_acc();
        observe(40);
        check_frame("H", 2, {4'd8, 4'd8, 4'd8, 4'd8},
                    {7'h4F, 7'h12, 7'h08, 7'h38}, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter CLK_HZ, default 100_000_000, meaning sysclk frequency in Hz.
REQ-003 SHALL have parameter SLOT_HZ, default 1000, meaning per-digit slot rate; SLOT_CYC = CLK_HZ/SLOT_HZ (integer, >= BLANK_CYC+2).
REQ-004 SHALL have parameter BLANK_CYC, default 64, meaning anti-ghost blanking cycles at the start of each slot.
REQ-005 SHALL have ports: sysclk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have ports: rst_n  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have ports: show  input  4*DIGITS  hex nibbles; digit i = show[4i+3:4i], digit 0 rightmost.
REQ-008 SHALL have ports: dp_in  input  DIGITS  decimal point request per digit, active-high.
REQ-009 SHALL have ports: blank_in  input  DIGITS  force digit dark, active-high.
REQ-010 SHALL have ports: lzs_en  input  1  leading-zero suppression enable.
REQ-011 SHALL have ports: bright  input  3  brightness, 0 = dimmest (1/8), 7 = full.
REQ-012 SHALL have ports: seg  output  7  segments active-low, bit6=A ... bit0=G.
REQ-013 SHALL have ports: dp  output  1  decimal point, active-low.
REQ-014 SHALL have ports: an  output  DIGITS  digit anodes, active-low, at most one low.
REQ-015 SHALL have ports: frame_start  output  1  one-cycle pulse when a new snapshot is taken.

Function
REQ-016 SHALL run slot counter 0..SLOT_CYC-1, wrapping to 0; on wrap, digit index advances, DIGITS-1 wraps to 0.
REQ-017 SHALL snapshot show, dp_in, blank_in, lzs_en, bright on the cycle the digit index wraps to 0, and on the first clock after rst_n deasserts; inputs are ignored otherwise (no tearing mid-frame).
REQ-018 SHALL pulse frame_start high for exactly the cycle following each snapshot.
REQ-019 SHALL hold all an bits high while slot counter < BLANK_CYC.
REQ-020 SHALL run a free 3-bit PWM counter incrementing every cycle; active digit's anode low only when slot counter >= BLANK_CYC and PWM counter <= snapshot bright.
REQ-021 SHALL treat digit i as dark when blank bit i set, or lzs set, i > 0, and digits DIGITS-1..i are all zero with no dp bit set among them; digit 0 is never suppressed.
REQ-022 SHALL drive dark digits with an high, seg 7'h7F, dp 1.
REQ-023 SHALL decode nibbles with the team glyph table: 0->0000001, 1->1001111, 8->0000000, A->0001000, F->0111000 (full table in package).
REQ-024 SHALL register seg, dp, an, frame_start; outputs lag internal counters by one cycle.
REQ-025 SHALL change seg/dp only while an is all high (during blanking), so no segment change is visible on a lit digit.
REQ-026 SHALL, when DIGITS = 1, keep digit index at 0 and snapshot every slot wrap.

Reset
REQ-027 SHALL, while rst_n low: counters, digit index, PWM counter, snapshot all zero; an all ones; seg 7'h7F; dp 1; frame_start 0.
REQ-028 SHALL honour rst_n assertion mid-slot immediately (asynchronous), darkening all digits in the same instant.

Structure
REQ-029 SHALL place the glyph table, SEG_OFF = 7'h7F constant and a SLOT_CYC computation function in shared package seg7_pkg.
REQ-030 SHALL use one sub-module seg7_glyph (combinational nibble-to-segment decode); counters, snapshot and suppression logic stay in seg7_scan.
REQ-031 SHALL reject illegal parameters (DIGITS out of range, SLOT_CYC < BLANK_CYC+2) at elaboration.

Verification (DIGITS=4, CLK_HZ=1000, SLOT_HZ=100 -> SLOT_CYC=10, BLANK_CYC=2)
REQ-032 SHALL check: release rst_n, show=16'h12AF, bright=7 -> frame_start one pulse; an sequence 1110,1101,1011,0111 lit 8 of 10 cycles each; seg 0111000, 0001000, 0010010, 1001111.
REQ-033 SHALL check: show=16'h0045, lzs_en=1 -> digits 3,2 an stay high; show=16'h0000 -> only digit 0 lit, seg 0000001; dp_in=4'b0100 with 16'h0005 -> digit 2 lit showing 0 with dp=0.
REQ-034 SHALL check: bright=0 -> each lit window shows an low exactly when PWM counter = 0 (1 of 8 cycles); bright=3 -> 4 of 8.
REQ-035 SHALL check: change show mid-frame -> outputs unchanged until next frame_start, then new value.
REQ-036 SHALL check: assert rst_n low mid-slot -> an=4'hF, seg=7'h7F, dp=1 without a clock edge; release -> restart at digit 0, slot 0.
REQ-037 SHALL check: blank_in=4'b0010 -> digit 1 never lit; an never has two bits low in any cycle.
